// File: rtl/fan_pkg.sv
// Shared constants for the fan control slice (fan_controller, fan_duty_ramp, pwm_controller).
// Holds the one-hot state encoding of fan_duty_ramp and the default duty width, ramp
// step, ramp period and kick duration, so that every instance agrees on them.
package fan_pkg;

  // One-hot state encoding; bit order [0..3] = IDLE, KICK, RAMP, HOLD.
  localparam logic [3:0] FR_IDLE = 4'b0001;
  localparam logic [3:0] FR_KICK = 4'b0010;
  localparam logic [3:0] FR_RAMP = 4'b0100;
  localparam logic [3:0] FR_HOLD = 4'b1000;

  typedef enum logic [3:0] {
    StIdle = FR_IDLE,
    StKick = FR_KICK,
    StRamp = FR_RAMP,
    StHold = FR_HOLD
  } fr_state_e;

  localparam int unsigned FAN_N            = 12;    // duty width
  localparam int unsigned FAN_SYS_FREQ     = 125;   // MHz
  localparam int unsigned FAN_RAMP_STEP_US = 100;   // us between ramp ticks
  localparam int unsigned FAN_STEP_SIZE    = 16;    // duty change per tick
  localparam int unsigned FAN_KICK_TICKS   = 2000;  // kick length in ticks

endpackage

// File: rtl/fan_tick_gen.sv
// Periodic tick prescaler for the fan duty ramp.
// Counts PERIOD clocks and raises a registered one-cycle tick at the end of each period.
// Ports:
//   clk     - system clock, posedge
//   reset_p - synchronous active-high reset
//   clear   - synchronous clear, holds the prescaler at its start while high
//   tick    - one-cycle pulse every PERIOD clocks
module fan_tick_gen #(
  parameter int unsigned PERIOD = 12500
) (
  input  logic clk,
  input  logic reset_p,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] CntLast = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  always_ff @(posedge clk) begin
    if (reset_p || clear) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == CntLast) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/fan_duty_ramp.sv
// Slew-rate limiter between the fan speed FSM and pwm_controller.
// Moves duty_out toward target_duty by STEP_SIZE per tick; stop forces zero at once.
// Optional kick-start (macro FAN_KICK_START_EN): a start from IDLE first drives full duty
// for KICK_TICKS ticks, then loads the target directly.
// Ports:
//   clk         - system clock, posedge
//   reset_p     - synchronous active-high reset
//   target_duty - requested duty
//   stop        - level, forces zero duty and IDLE while high
//   duty_out    - registered duty to pwm_controller
//   ramping     - high in RAMP
//   kick_active - high in KICK (tied 0 without FAN_KICK_START_EN)
//   state       - one-hot state {HOLD, RAMP, KICK, IDLE}
module fan_duty_ramp
  import fan_pkg::*;
#(
  parameter int unsigned N            = FAN_N,
  parameter int unsigned SYS_FREQ     = FAN_SYS_FREQ,
  parameter int unsigned RAMP_STEP_US = FAN_RAMP_STEP_US,
  parameter int unsigned STEP_SIZE    = FAN_STEP_SIZE,
  parameter int unsigned KICK_TICKS   = FAN_KICK_TICKS
) (
  input  logic         clk,
  input  logic         reset_p,
  input  logic [N-1:0] target_duty,
  input  logic         stop,
  output logic [N-1:0] duty_out,
  output logic         ramping,
  output logic         kick_active,
  output logic [3:0]   state
);

  if (STEP_SIZE < 1 || STEP_SIZE >= (1 << N) || KICK_TICKS < 1) begin : g_param_check
    $error("fan_duty_ramp: illegal STEP_SIZE or KICK_TICKS");
  end

  localparam logic [N:0]   StepExt = STEP_SIZE[N:0];
  localparam logic [N-1:0] StepN   = STEP_SIZE[N-1:0];

  logic tick;

  fan_tick_gen #(
    .PERIOD (SYS_FREQ * RAMP_STEP_US)
  ) u_tick_gen (
    .clk     (clk),
    .reset_p (reset_p),
    .clear   (stop),
    .tick    (tick)
  );

  fr_state_e      state_q, state_d;
  logic [N-1:0]   duty_q, duty_d;

  // Ramp arithmetic at N+1 bits so the magnitude compare cannot wrap.
  logic           dir_up;
  logic [N:0]     tgt_ext, cur_ext, mag;

  assign tgt_ext = {1'b0, target_duty};
  assign cur_ext = {1'b0, duty_q};
  assign dir_up  = (tgt_ext >= cur_ext);
  assign mag     = dir_up ? (tgt_ext - cur_ext) : (cur_ext - tgt_ext);

`ifdef FAN_KICK_START_EN
  localparam int unsigned KW = (KICK_TICKS > 1) ? $clog2(KICK_TICKS) : 1;
  localparam logic [KW-1:0] KickLast = KW'(KICK_TICKS - 1);

  logic [KW-1:0] kick_cnt_q, kick_cnt_d;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      kick_cnt_q <= '0;
    end else begin
      kick_cnt_q <= kick_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
`ifdef FAN_KICK_START_EN
    kick_cnt_d = kick_cnt_q;
`endif
    if (stop) begin
      state_d = StIdle;
      duty_d  = '0;
`ifdef FAN_KICK_START_EN
      kick_cnt_d = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          duty_d = '0;
          if (target_duty != '0) begin
`ifdef FAN_KICK_START_EN
            state_d    = StKick;
            duty_d     = '1;
            kick_cnt_d = '0;
`else
            state_d = StRamp;
`endif
          end
        end
`ifdef FAN_KICK_START_EN
        StKick: begin
          if (target_duty == '0) begin
            state_d    = StIdle;
            duty_d     = '0;
            kick_cnt_d = '0;
          end else if (tick) begin
            if (kick_cnt_q == KickLast) begin
              state_d    = StHold;
              duty_d     = target_duty;
              kick_cnt_d = '0;
            end else begin
              kick_cnt_d = kick_cnt_q + 1'b1;
            end
          end
        end
`endif
        StRamp: begin
          if (tick) begin
            if (mag <= StepExt) begin
              duty_d  = target_duty;
              state_d = (target_duty == '0) ? StIdle : StHold;
            end else if (dir_up) begin
              duty_d = duty_q + StepN;
            end else begin
              duty_d = duty_q - StepN;
            end
          end
        end
        StHold: begin
          // Any target change, including to 0, is followed through the ramp.
          if (target_duty != duty_q) begin
            state_d = StRamp;
          end
        end
        default: begin
          state_d = StIdle;
          duty_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q <= StIdle;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
    end
  end

  assign duty_out = duty_q;
  assign state    = state_q;
  assign ramping  = (state_q == StRamp);
`ifdef FAN_KICK_START_EN
  assign kick_active = (state_q == StKick);
`else
  assign kick_active = 1'b0;
`endif

endmodule
